// File: rtl/lsu_bus_if.sv
// Request/response bus between the execute stage and the load/store unit.
// Handshake: the master asserts req_i with we_i/size_i/unsigned_i/addr_i/wdata_i for
// one cycle; there is no ready, every request is accepted. The slave answers one
// cycle later: rvalid_o pulses for every load, err_o pulses for every rejected access.
interface lsu_bus_if #(
  parameter int ADDR_W = 16
);
  logic              req_i;
  logic              we_i;
  logic [1:0]        size_i;
  logic              unsigned_i;
  logic [ADDR_W-1:0] addr_i;
  logic [31:0]       wdata_i;
  logic [31:0]       rdata_o;
  logic              rvalid_o;
  logic              err_o;

  modport master (
    output req_i, we_i, size_i, unsigned_i, addr_i, wdata_i,
    input  rdata_o, rvalid_o, err_o
  );

  modport slave (
    input  req_i, we_i, size_i, unsigned_i, addr_i, wdata_i,
    output rdata_o, rvalid_o, err_o
  );
endinterface

// File: rtl/lsu_mmio.sv
// Load/store unit: byte-addressable data memory plus a memory-mapped board I/O window,
// with sub-word access, extension, error reporting and a registered load path.
module lsu_mmio #(
  parameter int DMEM_WORDS  = 2048,
  parameter int ADDR_W      = 16,
  parameter int NUM_HEX     = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  lsu_bus_if.slave           bus,
  input  logic [31:0]        io_sw_i,
  input  logic [31:0]        io_key_i,
  output logic [31:0]        io_ledr_o,
  output logic [31:0]        io_ledg_o,
  output logic [31:0]        io_lcd_o,
  output logic [7*NUM_HEX-1:0] io_hex_o
);

  localparam int unsigned DMEM_BYTES = 4 * DMEM_WORDS;
  localparam int          IDX_W      = $clog2(DMEM_WORDS);
  localparam logic [31:0] LEDR_A     = 32'h0000_7000;
  localparam logic [31:0] LEDG_A     = 32'h0000_7010;
  localparam logic [31:0] HEX_A      = 32'h0000_7020;
  localparam logic [31:0] LCD_A      = 32'h0000_7040;
  localparam logic [31:0] SW_A       = 32'h0000_7800;
  localparam logic [31:0] KEY_A      = 32'h0000_7810;

  logic [31:0] dmem [DMEM_WORDS];

  logic [31:0] rdata_q, rdata_d;
  logic        rvalid_q, rvalid_d;
  logic        err_q, err_d;
  logic [31:0] ledr_q, ledr_d;
  logic [31:0] ledg_q, ledg_d;
  logic [31:0] lcd_q, lcd_d;
  logic [6:0]  hex_q [NUM_HEX];
  logic [6:0]  hex_d [NUM_HEX];
  logic [31:0] sw_q [SYNC_STAGES];
  logic [31:0] sw_d [SYNC_STAGES];
  logic [31:0] key_q [SYNC_STAGES];
  logic [31:0] key_d [SYNC_STAGES];

  logic [31:0]      addr32;
  logic [IDX_W-1:0] dmem_idx;
  logic [2:0]       hex_idx;
  logic is_dmem, is_ledr, is_ledg, is_hex, is_lcd, is_sw, is_key, mapped;
  logic acc_err, wr_en, dmem_we;
  logic [3:0]  be;
  logic [31:0] wdata_rep;
  logic [31:0] rd_word;
  logic [31:0] ld_val;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Address decode, lane selection and error classification.
  always_comb begin
    addr32   = 32'(bus.addr_i);
    dmem_idx = addr32[2 +: IDX_W];
    hex_idx  = addr32[4:2];
    is_dmem  = addr32 < DMEM_BYTES;
    is_ledr  = addr32[31:2] == LEDR_A[31:2];
    is_ledg  = addr32[31:2] == LEDG_A[31:2];
    is_lcd   = addr32[31:2] == LCD_A[31:2];
    is_sw    = addr32[31:2] == SW_A[31:2];
    is_key   = addr32[31:2] == KEY_A[31:2];
    is_hex   = (addr32[31:5] == HEX_A[31:5]) && (int'(hex_idx) < NUM_HEX);
    mapped   = is_dmem | is_ledr | is_ledg | is_hex | is_lcd | is_sw | is_key;

    be        = 4'b0000;
    wdata_rep = bus.wdata_i;
    acc_err   = 1'b0;
    unique case (bus.size_i)
      2'b00: begin
        be        = 4'b0001 << addr32[1:0];
        wdata_rep = {4{bus.wdata_i[7:0]}};
      end
      2'b01: begin
        be        = addr32[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{bus.wdata_i[15:0]}};
        acc_err   = addr32[0];
      end
      2'b10: begin
        be      = 4'b1111;
        acc_err = addr32[1:0] != 2'b00;
      end
      default: acc_err = 1'b1;
    endcase
    if (!mapped || (bus.we_i && (is_sw || is_key))) acc_err = 1'b1;

    // Errors suppress every side effect, so the write enable is gated here.
    wr_en   = bus.req_i && bus.we_i && !acc_err;
    dmem_we = wr_en && is_dmem;
  end

  always_ff @(posedge clk_i) begin
    if (dmem_we) begin
      for (int l = 0; l < 4; l++) begin
        if (be[l]) dmem[dmem_idx][8*l +: 8] <= wdata_rep[8*l +: 8];
      end
    end
  end

  // Read mux, lane alignment and extension.
  always_comb begin
    rd_word = 32'h0;
    if (is_dmem)      rd_word = dmem[dmem_idx];
    else if (is_ledr) rd_word = ledr_q;
    else if (is_ledg) rd_word = ledg_q;
    else if (is_lcd)  rd_word = lcd_q;
    else if (is_sw)   rd_word = sw_q[SYNC_STAGES-1];
    else if (is_key)  rd_word = key_q[SYNC_STAGES-1];
    else if (is_hex) begin
      for (int i = 0; i < NUM_HEX; i++) begin
        if (int'(hex_idx) == i) rd_word = {25'h0, hex_q[i]};
      end
    end

    ld_byte = rd_word[{addr32[1:0], 3'b000} +: 8];
    ld_half = addr32[1] ? rd_word[31:16] : rd_word[15:0];
    unique case (bus.size_i)
      2'b00:   ld_val = bus.unsigned_i ? {24'h0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      2'b01:   ld_val = bus.unsigned_i ? {16'h0, ld_half} : {{16{ld_half[15]}}, ld_half};
      default: ld_val = rd_word;
    endcase
  end

  // Next-state for response, output registers and synchronisers.
  always_comb begin
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    err_d    = 1'b0;
    ledr_d   = ledr_q;
    ledg_d   = ledg_q;
    lcd_d    = lcd_q;
    for (int i = 0; i < NUM_HEX; i++) hex_d[i] = hex_q[i];
    sw_d[0]  = io_sw_i;
    key_d[0] = io_key_i;
    for (int k = 1; k < SYNC_STAGES; k++) begin
      sw_d[k]  = sw_q[k-1];
      key_d[k] = key_q[k-1];
    end

    if (bus.req_i) begin
      err_d = acc_err;
      if (!bus.we_i) begin
        rvalid_d = 1'b1;
        rdata_d  = acc_err ? 32'h0 : ld_val;
      end
    end

    if (wr_en) begin
      for (int l = 0; l < 4; l++) begin
        if (be[l]) begin
          if (is_ledr) ledr_d[8*l +: 8] = wdata_rep[8*l +: 8];
          if (is_ledg) ledg_d[8*l +: 8] = wdata_rep[8*l +: 8];
          if (is_lcd)  lcd_d[8*l +: 8]  = wdata_rep[8*l +: 8];
        end
      end
      // Digit registers are only 7 bits wide and live in byte lane 0.
      if (is_hex && be[0]) begin
        for (int i = 0; i < NUM_HEX; i++) begin
          if (int'(hex_idx) == i) hex_d[i] = wdata_rep[6:0];
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rdata_q  <= 32'h0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      ledr_q   <= 32'h0;
      ledg_q   <= 32'h0;
      lcd_q    <= 32'h0;
      for (int i = 0; i < NUM_HEX; i++) hex_q[i] <= 7'h0;
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sw_q[k]  <= 32'h0;
        key_q[k] <= 32'h0;
      end
    end else begin
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
      ledr_q   <= ledr_d;
      ledg_q   <= ledg_d;
      lcd_q    <= lcd_d;
      for (int i = 0; i < NUM_HEX; i++) hex_q[i] <= hex_d[i];
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sw_q[k]  <= sw_d[k];
        key_q[k] <= key_d[k];
      end
    end
  end

  always_comb begin
    bus.rdata_o  = rdata_q;
    bus.rvalid_o = rvalid_q;
    bus.err_o    = err_q;
    io_ledr_o    = ledr_q;
    io_ledg_o    = ledg_q;
    io_lcd_o     = lcd_q;
    for (int i = 0; i < NUM_HEX; i++) io_hex_o[7*i +: 7] = hex_q[i];
  end

endmodule

// File: tb/tb_lsu_mmio.sv
// Directed bench for lsu_mmio: memory sub-word access, I/O registers, synchroniser
// latency, error cases and asynchronous reset behaviour.
module tb_lsu_mmio;

  localparam int NUM_HEX = 8;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  logic [31:0] io_sw_i  = 32'h0;
  logic [31:0] io_key_i = 32'h0;
  logic [31:0] io_ledr_o, io_ledg_o, io_lcd_o;
  logic [7*NUM_HEX-1:0] io_hex_o;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  lsu_bus_if #(.ADDR_W(16)) bus ();

  lsu_mmio #(
    .DMEM_WORDS (2048),
    .ADDR_W     (16),
    .NUM_HEX    (NUM_HEX),
    .SYNC_STAGES(2)
  ) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .bus      (bus.slave),
    .io_sw_i  (io_sw_i),
    .io_key_i (io_key_i),
    .io_ledr_o(io_ledr_o),
    .io_ledg_o(io_ledg_o),
    .io_lcd_o (io_lcd_o),
    .io_hex_o (io_hex_o)
  );

  // clock / watchdog
  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // driver: present one request, return #1 after the edge that accepts it
  task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                       input logic [15:0] addr, input logic [31:0] wdata);
    bus.req_i      = 1'b1;
    bus.we_i       = we;
    bus.size_i     = size;
    bus.unsigned_i = uns;
    bus.addr_i     = addr;
    bus.wdata_i    = wdata;
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    bus.req_i = 1'b0;
    bus.we_i  = 1'b0;
    @(posedge clk_i);
    #1;
  endtask

  task automatic st(input string tag, input logic [1:0] size, input logic [15:0] addr,
                    input logic [31:0] data, input logic exp_err);
    issue(1'b1, size, 1'b0, addr, data);
    chk({tag, "_err"}, 64'(bus.err_o), 64'(exp_err));
    chk({tag, "_rvalid"}, 64'(bus.rvalid_o), 64'(0));
  endtask

  task automatic ld(input string tag, input logic [1:0] size, input logic uns,
                    input logic [15:0] addr, input logic [31:0] exp_data, input logic exp_err);
    exp_q.push_back(exp_data);
    issue(1'b0, size, uns, addr, 32'h0);
    chk({tag, "_data"}, 64'(bus.rdata_o), 64'(exp_q.pop_front()));
    chk({tag, "_rvalid"}, 64'(bus.rvalid_o), 64'(1));
    chk({tag, "_err"}, 64'(bus.err_o), 64'(exp_err));
  endtask

  initial begin
    bus.req_i = 1'b0; bus.we_i = 1'b0; bus.size_i = 2'b00; bus.unsigned_i = 1'b0;
    bus.addr_i = 16'h0; bus.wdata_i = 32'h0;
    io_key_i = 32'h0000_000F;

    // reset state
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_rdata", 64'(bus.rdata_o), 64'(0));
    chk("rst_rvalid", 64'(bus.rvalid_o), 64'(0));
    chk("rst_err", 64'(bus.err_o), 64'(0));
    chk("rst_ledr", 64'(io_ledr_o), 64'(0));
    chk("rst_ledg", 64'(io_ledg_o), 64'(0));
    chk("rst_lcd", 64'(io_lcd_o), 64'(0));
    chk("rst_hex", 64'(io_hex_o), 64'(0));
    rst_i = 1'b0;
    idle();

    // LEDR store / load, then reset mid-load
    ld("ledr0", 2'b10, 1'b0, 16'h7000, 32'h0, 1'b0);
    st("sw_ledr", 2'b10, 16'h7000, 32'h0000_03FF, 1'b0);
    chk("ledr_out", 64'(io_ledr_o), 64'(32'h3FF));
    ld("ledr_rd", 2'b10, 1'b0, 16'h7000, 32'h0000_03FF, 1'b0);
    bus.req_i = 1'b1; bus.we_i = 1'b0; bus.addr_i = 16'h7000; bus.size_i = 2'b10;
    #2 rst_i = 1'b1;
    #1;
    chk("rst_mid_rdata", 64'(bus.rdata_o), 64'(0));
    chk("rst_mid_rvalid", 64'(bus.rvalid_o), 64'(0));
    chk("rst_mid_ledr", 64'(io_ledr_o), 64'(0));
    @(posedge clk_i); #1;
    chk("rst_mid_rvalid2", 64'(bus.rvalid_o), 64'(0));
    chk("rst_mid_err2", 64'(bus.err_o), 64'(0));
    rst_i = 1'b0;
    idle();
    ld("ledr_after_rst", 2'b10, 1'b0, 16'h7000, 32'h0, 1'b0);

    // DMEM sub-word access
    st("sw100", 2'b10, 16'h0100, 32'h8899_AABB, 1'b0);
    st("sb101", 2'b00, 16'h0101, 32'h0000_0011, 1'b0);
    ld("lw100", 2'b10, 1'b0, 16'h0100, 32'h8899_11BB, 1'b0);
    ld("lb103", 2'b00, 1'b0, 16'h0103, 32'hFFFF_FF88, 1'b0);
    ld("lbu103", 2'b00, 1'b1, 16'h0103, 32'h0000_0088, 1'b0);
    ld("lh102", 2'b01, 1'b0, 16'h0102, 32'hFFFF_8899, 1'b0);
    ld("lhu100", 2'b01, 1'b1, 16'h0100, 32'h0000_11BB, 1'b0);
    ld("lb101", 2'b00, 1'b0, 16'h0101, 32'h0000_0011, 1'b0);

    // idle cycle: no pulses, rdata held
    idle();
    chk("idle_rvalid", 64'(bus.rvalid_o), 64'(0));
    chk("idle_err", 64'(bus.err_o), 64'(0));
    chk("idle_rdata_hold", 64'(bus.rdata_o), 64'(32'h0000_0011));

    // alignment and size errors
    st("sh102", 2'b01, 16'h0102, 32'h0000_1234, 1'b0);
    ld("lw100_b", 2'b10, 1'b0, 16'h0100, 32'h1234_11BB, 1'b0);
    ld("lh101_err", 2'b01, 1'b0, 16'h0101, 32'h0, 1'b1);
    st("sw104", 2'b10, 16'h0104, 32'h5566_7788, 1'b0);
    st("sw106_err", 2'b10, 16'h0106, 32'hDEAD_BEEF, 1'b1);
    ld("lw104_keep", 2'b10, 1'b0, 16'h0104, 32'h5566_7788, 1'b0);
    ld("size11_err", 2'b11, 1'b0, 16'h0100, 32'h0, 1'b1);
    st("size11_st_err", 2'b11, 16'h0104, 32'h0, 1'b1);
    ld("lw104_keep2", 2'b10, 1'b0, 16'h0104, 32'h5566_7788, 1'b0);

    // peripheral registers
    st("sb7024", 2'b00, 16'h7024, 32'h0000_007F, 1'b0);
    chk("hex1_set", 64'(io_hex_o), 64'(56'h7F << 7));
    st("sb7025", 2'b00, 16'h7025, 32'h0000_0012, 1'b0);
    chk("hex1_keep", 64'(io_hex_o), 64'(56'h7F << 7));
    ld("lw7024", 2'b10, 1'b0, 16'h7024, 32'h0000_007F, 1'b0);
    st("sw703c", 2'b10, 16'h703C, 32'hFFFF_FF85, 1'b0);
    chk("hex7_set", 64'(io_hex_o), 64'((56'h05 << 49) | (56'h7F << 7)));
    st("sh7012", 2'b01, 16'h7012, 32'h0000_ABCD, 1'b0);
    chk("ledg_out", 64'(io_ledg_o), 64'(32'hABCD_0000));
    ld("lb7013", 2'b00, 1'b0, 16'h7013, 32'hFFFF_FFAB, 1'b0);
    st("sw7040", 2'b10, 16'h7040, 32'h1357_9BDF, 1'b0);
    chk("lcd_out", 64'(io_lcd_o), 64'(32'h1357_9BDF));
    ld("unmapped7004", 2'b10, 1'b0, 16'h7004, 32'h0, 1'b1);

    // switch synchroniser latency
    ld("sw_pre", 2'b10, 1'b0, 16'h7800, 32'h0, 1'b0);
    io_sw_i = 32'h0000_00A5;
    ld("sw_lat1", 2'b10, 1'b0, 16'h7800, 32'h0, 1'b0);
    ld("sw_lat2", 2'b10, 1'b0, 16'h7800, 32'h0, 1'b0);
    ld("sw_lat3", 2'b10, 1'b0, 16'h7800, 32'h0000_00A5, 1'b0);
    st("st_sw_err", 2'b10, 16'h7800, 32'h1, 1'b1);
    ld("key_rd", 2'b10, 1'b0, 16'h7810, 32'h0000_000F, 1'b0);
    st("st_key_err", 2'b00, 16'h7810, 32'h1, 1'b1);

    // write-first and DMEM boundary
    st("sw200", 2'b10, 16'h0200, 32'hCAFE_F00D, 1'b0);
    ld("lw200_wf", 2'b10, 1'b0, 16'h0200, 32'hCAFE_F00D, 1'b0);
    st("sw1ffc", 2'b10, 16'h1FFC, 32'h0BAD_CAFE, 1'b0);
    ld("lw1ffc", 2'b10, 1'b0, 16'h1FFC, 32'h0BAD_CAFE, 1'b0);
    ld("lw2000_err", 2'b10, 1'b0, 16'h2000, 32'h0, 1'b1);
    ld("lw6000_err", 2'b10, 1'b0, 16'h6000, 32'h0, 1'b1);
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lsu_mmio.md
# lsu_mmio

Parametrised load/store unit for the single-cycle/pipelined RISC-V core: a byte-addressable data memory plus a memory-mapped peripheral window (LEDs, LCD, 7-segment bank, switches, keys). It adds sub-word access (byte/half/word), sign/zero extension, alignment and decode error reporting, input synchronisers and a registered, one-cycle load path. It sits between the execute stage and the board I/O.

## Interface
- DMEM_WORDS, 2048, data memory depth in 32-bit words (power of 2); DMEM occupies byte addresses 0 .. 4*DMEM_WORDS-1
- ADDR_W, 16, address width in bits; 4*DMEM_WORDS must be ≤ 0x7000
- NUM_HEX, 8, number of 7-segment digits (1..8)
- SYNC_STAGES, 2, flop stages on io_sw_i/io_key_i (≥2)

Ports:
- clk_i  in  1  clock; all state on rising edge
- rst_i  in  1  reset, asynchronous, active-high
- req_i  in  1  access request, one per cycle, never stalled
- we_i  in  1  1 = store, 0 = load
- size_i  in  2  00 byte, 01 half, 10 word, 11 illegal
- unsigned_i  in  1  load zero-extends when 1
- addr_i  in  ADDR_W  byte address
- wdata_i  in  32  store data, right-aligned
- rdata_o  out  32  load result
- rvalid_o  out  1  load result valid, one-cycle pulse
- err_o  out  1  access error, one-cycle pulse
- io_sw_i  in  32  switches, asynchronous
- io_key_i  in  32  keys, asynchronous
- io_ledr_o, io_ledg_o, io_lcd_o  out  32 each  output registers
- io_hex_o  out  7*NUM_HEX  digit i on bits [7i+6:7i]

## Operation
- Map: DMEM at 0 .. 4*DMEM_WORDS-1; LEDR 0x7000, LEDG 0x7010, HEX i at 0x7020+4i (i<NUM_HEX), LCD 0x7040; SW 0x7800, KEY 0x7810 (read-only). All else is unmapped.
- Little-endian lanes: byte uses lane addr[1:0]; half uses lanes {addr[1],0}/{addr[1],1}; word uses all four.
- Store: wdata byte/half replicated to the selected lanes, and only those lanes are written (DMEM and the 32-bit output registers). HEX registers are 7 bits: updated from wdata bits [6:0] only when lane 0 is enabled; other lanes are ignored.
- Load: the selected lanes are right-aligned, then sign-extended (unsigned_i=0) or zero-extended. HEX reads zero-extend to 32 bits. SW/KEY return the last synchroniser stage.
- Error (err_o=1, no write, rdata_o=0): size_i=11; half with addr[0]=1; word with addr[1:0]≠0; unmapped address; store to SW/KEY. The error check takes priority over any side effect.
- DMEM contents are not reset (RAM inference) and start undefined. All registers and synchronisers are reset.

## Timing
- Reset: rdata_o=0, rvalid_o=0, err_o=0, all io_*_o=0, synchronisers=0. Asserting reset mid-access drops any pending rvalid_o/err_o.
- Store: written at the rising edge where req_i&we_i. io_*_o show the new value in the following cycle. err_o for a bad store pulses in the following cycle.
- Load: at the rising edge where req_i&!we_i, the result is registered. rdata_o, rvalid_o (and err_o on error) are valid in the following cycle only. rvalid_o=1 even on error. rdata_o holds its value when there is no load.
- Back-to-back accesses are allowed every cycle. A load in cycle N+1 of an address stored in cycle N returns the new data (write-first).
- Input latency: an io_sw_i change is visible to loads SYNC_STAGES cycles later, plus the 1-cycle load latency.
- req_i=0: no state change; rvalid_o=err_o=0 next cycle.

## Test plan
- Reset with rst_i high mid-load: all outputs 0 and rvalid_o=0 the next cycle. After release, LW 0x7000 returns 0.
- SW 0x100 = 0x8899AABB, then SB 0x101 = 0x11, then LW 0x100 -> 0x889911BB. LB 0x103 -> 0xFFFFFF88. LBU 0x103 -> 0x00000088. LH 0x102 -> 0xFFFF8899.
- SH 0x102 (addr[0]=0 ok); LH 0x101 -> err_o=1, rvalid_o=1, rdata_o=0. SW 0x106 -> err_o=1, memory unchanged. size_i=11 -> err_o=1.
- SW 0x7000 = 0x3FF -> io_ledr_o=0x3FF the next cycle. SB 0x7024 = 0x7F -> HEX1 bits=0x7F. SB 0x7025 -> HEX1 unchanged.
- Drive io_sw_i=0xA5 and issue LW 0x7800 every cycle: first 0xA5 appears exactly SYNC_STAGES+1 cycles after the change. SW 0x7800 -> err_o=1.
- Store then load of the same address in consecutive cycles -> new data. LW 0x6000 with DMEM_WORDS=2048 (outside 0..0x1FFF) -> err_o=1, rdata_o=0.
